// File: rtl/seq_axi_writer.sv
// Write-back stage: buffers 64-bit sequence records in a FIFO and writes them to memory
// as AXI4 INCR bursts starting at a per-block base address, then reports {err, count}.
module seq_axi_writer #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 6,
  parameter int AXI_STRB_W = 8,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [AXI_ADDR_W-1:0] cfg_addr,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,

  input  logic [63:0]           seq_data,
  input  logic                  seq_last,
  input  logic                  seq_vld,
  output logic                  seq_rdy,

  output logic [AXI_ID_W-1:0]   axi_awid,
  output logic [AXI_ADDR_W-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,

  output logic [AXI_DATA_W-1:0] axi_wdata,
  output logic [AXI_STRB_W-1:0] axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,

  input  logic [AXI_ID_W-1:0]   axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,

  output logic [32:0]           done_data,
  output logic                  done_vld,
  input  logic                  done_rdy,

  output logic [2:0]            dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising clock edge where
  // valid and ready are both high; a valid, once raised, holds its payload until then.

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BLEN_W = $clog2(MAX_BURST) + 1;

  localparam logic [9:0]        MAX_BURST_PB = 10'(MAX_BURST);
  localparam logic [BLEN_W-1:0] MAX_BURST_BL = BLEN_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  FIFO_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_AW      = 3'd2,
    S_W       = 3'd3,
    S_B       = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [AXI_ADDR_W-1:0] addr_q;
  logic [31:0]           count_q;
  logic                  err_q;
  logic                  last_seen_q;
  logic [BLEN_W-1:0]     blen_q, blen_d;
  logic [BLEN_W-1:0]     beat_q;

  logic [AXI_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;

  logic                  push, pop;
  logic                  last_beat;
  logic [9:0]            page_beats;
  logic [BLEN_W-1:0]     lim;
  logic [CNT_W-1:0]      lim_c;
  logic                  unused_bid;

  assign unused_bid = ^axi_bid;

  // Beats left before the next 4KB page boundary; a burst never runs past it.
  assign page_beats = 10'((13'd4096 - {1'b0, addr_q[11:0]}) >> 3);
  assign lim        = (page_beats >= MAX_BURST_PB) ? MAX_BURST_BL : page_beats[BLEN_W-1:0];
  assign lim_c      = CNT_W'(lim);

  assign last_beat  = (beat_q == blen_q - BLEN_W'(1));
  assign push       = seq_vld && seq_rdy;
  assign pop        = (state_q == S_W) && axi_wready;

  // Every output below comes from a register or the state; no input reaches an output valid.
  assign cfg_rdy     = (state_q == S_IDLE);
  assign seq_rdy     = (fifo_cnt_q != FIFO_FULL) && (state_q != S_IDLE) &&
                       (state_q != S_DONE) && !last_seen_q;
  assign axi_awid    = '0;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(blen_q - BLEN_W'(1));
  assign axi_awsize  = 3'b011;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = (state_q == S_AW);
  assign axi_wdata   = mem[rd_ptr_q];
  assign axi_wstrb   = '1;
  assign axi_wlast   = (state_q == S_W) && last_beat;
  assign axi_wvalid  = (state_q == S_W);
  assign axi_bready  = (state_q == S_B);
  assign done_data   = {err_q, count_q};
  assign done_vld    = (state_q == S_DONE);
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    blen_d  = blen_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_vld) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (fifo_cnt_q >= lim_c) begin
          state_d = S_AW;
          blen_d  = lim;
        end else if (last_seen_q && (fifo_cnt_q != '0)) begin
          state_d = S_AW;
          blen_d  = fifo_cnt_q[BLEN_W-1:0];
        end else if (last_seen_q) begin
          state_d = S_DONE;
        end
      end
      S_AW: begin
        if (axi_awready) state_d = S_W;
      end
      S_W: begin
        if (axi_wready && last_beat) state_d = S_B;
      end
      S_B: begin
        if (axi_bvalid) state_d = S_COLLECT;
      end
      S_DONE: begin
        if (done_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      blen_q  <= '0;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      if ((state_q == S_IDLE) && cfg_vld) begin
        addr_q      <= cfg_addr;
        count_q     <= '0;
        err_q       <= 1'b0;
        last_seen_q <= 1'b0;
      end
      if (push && seq_last) last_seen_q <= 1'b1;
      if ((state_q == S_AW) && axi_awready) beat_q <= '0;
      if (pop) beat_q <= beat_q + BLEN_W'(1);
      if ((state_q == S_B) && axi_bvalid) begin
        err_q   <= err_q | (axi_bresp != 2'b00);
        addr_q  <= addr_q + (AXI_ADDR_W'(blen_q) << 3);
        count_q <= count_q + 32'(blen_q);
      end
    end
  end

  // Record FIFO; simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= AXI_DATA_W'(seq_data);
  end

endmodule

// File: tb/tb_seq_axi_writer.sv
// Directed bench for seq_axi_writer: a record source and AXI slave run alongside a linear
// main sequence; beat data and burst fields are scored against bench-side expectations.
module tb_seq_axi_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_addr;
  logic        cfg_vld, cfg_rdy;
  logic [63:0] seq_data;
  logic        seq_last, seq_vld, seq_rdy;
  logic [5:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [5:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [32:0] done_data;
  logic        done_vld, done_rdy;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  seq_axi_writer dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .seq_data(seq_data), .seq_last(seq_last), .seq_vld(seq_vld), .seq_rdy(seq_rdy),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .done_data(done_data), .done_vld(done_vld), .done_rdy(done_rdy),
    .dbg_state(dbg_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [39:0] exp_aw_q[$];
  logic [64:0] send_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] model_addr = '0;
  bit          stall_en = 1'b0;
  int          bad_burst = -1;
  int          b_idx = 0;
  int          w_hs = 0;
  int          w_beat = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record source: inputs change on the falling edge, the handshake lands on the next rise.
  initial begin
    bit hs;
    hs = 1'b0;
    seq_vld = 1'b0; seq_data = '0; seq_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin hs = 1'b0; seq_vld = 1'b0; continue; end
      if (hs && send_q.size() > 0) void'(send_q.pop_front());
      hs = 1'b0;
      if (send_q.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
        seq_vld = 1'b1;
        {seq_last, seq_data} = send_q[0];
      end else begin
        seq_vld = 1'b0;
      end
      if (seq_vld && seq_rdy) begin
        hs = 1'b1;
        exp_q.push_back(seq_data);
      end
    end
  end

  // AW slave: address continuity, page-boundary and stall-stability checks.
  initial begin
    bit          held;
    logic [39:0] held_v, obs;
    int          end_off;
    held = 1'b0; held_v = '0;
    axi_awready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin held = 1'b0; axi_awready = 1'b0; continue; end
      obs = {axi_awaddr, axi_awlen};
      if (axi_awvalid && held) check("aw_stable", obs, held_v);
      axi_awready = !stall_en || $urandom_range(0, 2) == 0;
      if (axi_awvalid && axi_awready) begin
        held = 1'b0;
        end_off = int'(axi_awaddr[11:0]) + (int'(axi_awlen) + 1) * 8;
        check("aw_addr_seq", axi_awaddr, model_addr);
        check("aw_4k_cross", end_off > 4096, 0);
        check("aw_len_max", axi_awlen > 8'd15, 0);
        if (exp_aw_q.size() > 0) check("aw_fields", obs, exp_aw_q.pop_front());
        aw_len_q.push_back(axi_awlen);
        model_addr = model_addr + ((32'(axi_awlen) + 32'd1) << 3);
      end else begin
        held   = axi_awvalid;
        held_v = obs;
      end
    end
  end

  // W slave: beat data pops the scoreboard; wlast expected on the burst's final beat.
  initial begin
    axi_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin axi_wready = 1'b0; continue; end
      axi_wready = !stall_en || $urandom_range(0, 2) != 0;
      if (axi_wvalid) check("w_after_aw", aw_len_q.size() > 0, 1);
      if (axi_wvalid && axi_wready && aw_len_q.size() > 0) begin
        check("w_have_exp", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("w_data", axi_wdata, exp_q.pop_front());
        check("w_last", axi_wlast, w_beat == int'(aw_len_q[0]));
        check("w_strb", axi_wstrb, 8'hff);
        w_hs++;
        if (w_beat == int'(aw_len_q[0])) begin
          w_beat = 0;
          void'(aw_len_q.pop_front());
        end else begin
          w_beat++;
        end
      end
    end
  end

  // B slave: answers only once bready is up; burst number bad_burst gets SLVERR.
  initial begin
    axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin axi_bvalid = 1'b0; continue; end
      axi_bvalid = axi_bready && (!stall_en || $urandom_range(0, 2) == 0);
      axi_bresp  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
      if (axi_bvalid) b_idx++;
    end
  end

  task automatic start_block(input logic [31:0] base, input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!cfg_rdy && t < 1000) begin @(negedge clk); t++; end
    check("cfg_rdy_idle", cfg_rdy, 1);
    model_addr = base;
    b_idx      = 0;
    cfg_addr   = base;
    cfg_vld    = 1'b1;
    for (int i = 0; i < n; i++) send_q.push_back({i == n - 1, $urandom(), $urandom()});
    @(negedge clk);
    cfg_vld = 1'b0;
    check("cfg_rdy_busy", cfg_rdy, 0);
  endtask

  task automatic finish_block(input int n, input bit err);
    int t;
    t = 0;
    while (!done_vld && t < 20000) begin @(negedge clk); t++; end
    check("done_vld", done_vld, 1);
    check("done_data", done_data, {err, 32'(n)});
    check("beats_drained", exp_q.size(), 0);
    check("aw_drained", exp_aw_q.size(), 0);
    @(negedge clk);
    check("done_hold", done_data, {err, 32'(n)});
    done_rdy = 1'b1;
    @(negedge clk);
    done_rdy = 1'b0;
    check("cfg_rdy_after_done", cfg_rdy, 1);
    check("done_vld_cleared", done_vld, 0);
  endtask

  initial begin
    int t;
    cfg_addr = '0; cfg_vld = 1'b0; done_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_rdy", cfg_rdy, 1);
    check("rst_seq_rdy", seq_rdy, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_done_vld", done_vld, 0);
    check("rst_awsize", axi_awsize, 3'b011);
    check("rst_awburst", axi_awburst, 2'b01);
    check("rst_awid", axi_awid, 0);
    check("rst_wstrb", axi_wstrb, 8'hff);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #2 rst = 1'b1;

    // Three records, one short burst.
    exp_aw_q.push_back({32'h1000, 8'd2});
    start_block(32'h1000, 3);
    finish_block(3, 1'b0);

    // 40 records: two full bursts and a tail.
    exp_aw_q.push_back({32'h2000, 8'd15});
    exp_aw_q.push_back({32'h2080, 8'd15});
    exp_aw_q.push_back({32'h2100, 8'd7});
    start_block(32'h2000, 40);
    finish_block(40, 1'b0);

    // Burst split at the 4KB boundary.
    exp_aw_q.push_back({32'h1FE0, 8'd3});
    exp_aw_q.push_back({32'h2000, 8'd5});
    start_block(32'h1FE0, 10);
    finish_block(10, 1'b0);

    // Random stalls on every channel.
    stall_en = 1'b1;
    start_block(32'h7F40, 100);
    finish_block(100, 1'b0);
    stall_en = 1'b0;

    // Error response on the second burst.
    bad_burst = 1;
    exp_aw_q.push_back({32'h3000, 8'd15});
    exp_aw_q.push_back({32'h3080, 8'd15});
    exp_aw_q.push_back({32'h3100, 8'd7});
    start_block(32'h3000, 40);
    finish_block(40, 1'b1);
    bad_burst = -1;

    // Reset in the middle of the fifth W beat.
    w_hs = 0;
    start_block(32'h5000, 40);
    t = 0;
    while (w_hs < 4 && t < 2000) begin @(negedge clk); t++; end
    check("reach_beat5", w_hs >= 4, 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("abort_awvalid", axi_awvalid, 0);
    check("abort_wvalid", axi_wvalid, 0);
    check("abort_bready", axi_bready, 0);
    check("abort_done_vld", done_vld, 0);
    check("abort_seq_rdy", seq_rdy, 0);
    check("abort_cfg_rdy", cfg_rdy, 1);
    repeat (2) @(negedge clk);
    send_q.delete();
    exp_q.delete();
    exp_aw_q.delete();
    aw_len_q.delete();
    w_beat = 0;
    @(posedge clk); #2 rst = 1'b1;

    exp_aw_q.push_back({32'h6000, 8'd9});
    start_block(32'h6000, 10);
    finish_block(10, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
